ks_loop_filter: RTL and testbench

Feedback loop filter for the Karplus-Strong voice. It reads each sample leaving the voice's delay-line RAM and forms the two-tap average of that sample and the previous one. The average is scaled by a decay gain and by a note-envelope fade level, and the result is returned to the delay line as the filtered feedback word. A small play/release state machine applies the fade: the loop silences smoothly on note-off and restarts at full level on trigger.

---
 rtl/ks_loop_filter_if.sv | 24 ++
 rtl/ks_loop_filter.sv | 147 ++++++++++++++
 tb/tb_ks_loop_filter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ks_loop_filter_if.sv
// Sample-stream and control bundle between the Karplus-Strong delay line and its loop filter.
// Slave side is the filter; master side drives samples and note events.
interface ks_loop_filter_if #(
  parameter int DATA_W = 32
);
  logic signed [DATA_W-1:0] q_in;
  logic                     q_valid;
  logic        [15:0]       decay;
  logic                     trig;
  logic                     note_off;
  logic signed [DATA_W-1:0] dfilter;
  logic                     dfilter_valid;
  logic        [1:0]        state;

  modport master (
    output q_in, q_valid, decay, trig, note_off,
    input  dfilter, dfilter_valid, state
  );

  modport slave (
    input  q_in, q_valid, decay, trig, note_off,
    output dfilter, dfilter_valid, state
  );
endinterface

// File: rtl/ks_loop_filter.sv
// Karplus-Strong feedback filter: two-tap average, Q0.16 decay gain and a Q1.16 note fade
// driven by a play/release FSM, in a fixed three-stage pipeline.
module ks_loop_filter #(
  parameter int DATA_W    = 32,
  parameter int FADE_STEP = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  ks_loop_filter_if.slave bus
);
  localparam int          PW        = DATA_W + 18;
  localparam logic [16:0] FADE_FULL = 17'h10000;
  localparam logic [16:0] STEP      = 17'(FADE_STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_REL  = 2'd2
  } state_t;

  // Signed product of two extended operands, floored by 2^16 and cut back to sample width.
  function automatic logic signed [DATA_W-1:0] scale_q16(
    input logic signed [PW-1:0] a,
    input logic signed [PW-1:0] b
  );
    logic signed [PW-1:0] p;
    p = a * b;
    p = p >>> 16;
    return p[DATA_W-1:0];
  endfunction

  state_t                   r_state, w_state_nxt;
  logic        [16:0]       r_fade, w_fade_nxt;
  logic signed [DATA_W-1:0] r_prev, w_prev_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_fade_nxt  = r_fade;
    w_prev_nxt  = r_prev;
    if (bus.q_valid) w_prev_nxt = bus.q_in;
    case (r_state)
      S_PLAY: if (bus.note_off) w_state_nxt = S_REL;
      S_REL: begin
        if (bus.q_valid) begin
          w_fade_nxt = (r_fade > STEP) ? (r_fade - STEP) : 17'd0;
          if (w_fade_nxt == 17'd0) w_state_nxt = S_IDLE;
        end
      end
      default: ;
    endcase
    // A new note overrides release/idle and restarts the average from silence.
    if (bus.trig) begin
      w_state_nxt = S_PLAY;
      w_fade_nxt  = FADE_FULL;
      if (!bus.q_valid) w_prev_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_fade  <= '0;
      r_prev  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fade  <= w_fade_nxt;
      r_prev  <= w_prev_nxt;
    end
  end

  // ---- stage 0: pair sum, gain/fade capture ----
  logic signed [DATA_W-1:0] w_prev_eff;
  logic signed [DATA_W:0]   w_sum;
  logic        [16:0]       w_fade_cap;
  logic signed [DATA_W:0]   r_sum_p0;
  logic        [15:0]       r_decay_p0;
  logic        [16:0]       r_fade_p0;
  logic                     r_vld_p0;

  assign w_prev_eff = bus.trig ? '0 : r_prev;
  assign w_sum      = $signed({bus.q_in[DATA_W-1], bus.q_in})
                    + $signed({w_prev_eff[DATA_W-1], w_prev_eff});
  assign w_fade_cap = bus.trig ? FADE_FULL : r_fade;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p0   <= 1'b0;
      r_sum_p0   <= '0;
      r_decay_p0 <= '0;
      r_fade_p0  <= '0;
    end else begin
      r_vld_p0 <= bus.q_valid;
      if (bus.q_valid) begin
        r_sum_p0   <= w_sum;
        r_decay_p0 <= bus.decay;
        r_fade_p0  <= w_fade_cap;
      end
    end
  end

  // ---- stage 1: floored average, decay gain ----
  logic signed [DATA_W-1:0] w_avg_p1;
  logic signed [PW-1:0]     w_avg_ext, w_decay_ext;
  logic signed [DATA_W-1:0] r_g_p1;
  logic        [16:0]       r_fade_p1;
  logic                     r_vld_p1;

  assign w_avg_p1    = r_sum_p0[DATA_W:1];
  assign w_avg_ext   = {{(PW-DATA_W){w_avg_p1[DATA_W-1]}}, w_avg_p1};
  assign w_decay_ext = {{(PW-16){1'b0}}, r_decay_p0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p1  <= 1'b0;
      r_g_p1    <= '0;
      r_fade_p1 <= '0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      if (r_vld_p0) begin
        r_g_p1    <= scale_q16(w_avg_ext, w_decay_ext);
        r_fade_p1 <= r_fade_p0;
      end
    end
  end

  // ---- stage 2: fade level, output register ----
  logic signed [PW-1:0]     w_g_ext, w_fade_ext;
  logic signed [DATA_W-1:0] r_dfilter_p2;
  logic                     r_vld_p2;

  assign w_g_ext    = {{(PW-DATA_W){r_g_p1[DATA_W-1]}}, r_g_p1};
  assign w_fade_ext = {{(PW-17){1'b0}}, r_fade_p1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p2     <= 1'b0;
      r_dfilter_p2 <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_dfilter_p2 <= scale_q16(w_g_ext, w_fade_ext);
    end
  end

  assign bus.dfilter       = r_dfilter_p2;
  assign bus.dfilter_valid = r_vld_p2;
  assign bus.state         = r_state;
endmodule

// File: tb/tb_ks_loop_filter.sv
// Scoreboard bench for ks_loop_filter: a behavioural note/fade model predicts each output word
// and its arrival cycle; a negedge monitor pops and compares them.
module tb_ks_loop_filter;
  localparam int     DATA_W = 32;
  localparam longint FS     = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ks_loop_filter_if #(.DATA_W(DATA_W)) bus ();

  ks_loop_filter #(.DATA_W(DATA_W), .FADE_STEP(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    longint val;
    longint due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  int     m_state = 0;
  longint m_fade  = 0;
  longint m_prev  = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.dfilter_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("dfilter", longint'(bus.dfilter), e.val);
        chk("latency", cyc, e.due);
      end
    end
  end

  // One clock of stimulus; also checks the FSM state left by the previous cycle.
  task automatic step(input logic v, input longint q, input logic [15:0] dec,
                      input logic tg, input logic no);
    longint pe, sum, avg, g, f, y;
    exp_t   x;
    @(posedge clk);
    #1;
    chk("state", longint'(bus.state), longint'(m_state));
    bus.q_valid  = v;
    bus.q_in     = q[DATA_W-1:0];
    bus.decay    = dec;
    bus.trig     = tg;
    bus.note_off = no;
    if (v) begin
      pe    = tg ? 0 : m_prev;
      sum   = q + pe;
      avg   = sum >>> 1;
      g     = (avg * longint'(dec)) >>> 16;
      f     = tg ? 65536 : m_fade;
      y     = (g * f) >>> 16;
      x.val = y;
      x.due = cyc + 3;
      sb.push_back(x);
    end
    if (tg) begin
      m_state = 1;
      m_fade  = 65536;
      m_prev  = v ? q : 0;
    end else begin
      if (v) m_prev = q;
      if (m_state == 1 && no) begin
        m_state = 2;
      end else if (m_state == 2 && v) begin
        m_fade = (m_fade > FS) ? m_fade - FS : 0;
        if (m_fade == 0) m_state = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    bus.q_valid  = 1'b0;
    bus.q_in     = '0;
    bus.decay    = '0;
    bus.trig     = 1'b0;
    bus.note_off = 1'b0;
    reset_n      = 1'b0;
    sb.delete();
    m_state = 0;
    m_fade  = 0;
    m_prev  = 0;
    #1;
    chk("rst_dfilter", longint'(bus.dfilter), 0);
    chk("rst_valid", longint'(bus.dfilter_valid), 0);
    chk("rst_state", longint'(bus.state), 0);
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.q_valid  = 1'b0;
    bus.q_in     = '0;
    bus.decay    = '0;
    bus.trig     = 1'b0;
    bus.note_off = 1'b0;
    do_reset(3);

    // Idle: fade is zero so every sample comes back as zero.
    for (int i = 0; i < 5; i++) step(1'b1, 1000, 16'hFFFF, 1'b0, 1'b0);
    idle(4);

    // Basic average: 499 then 1999.
    step(1'b1, 1000, 16'hFFFF, 1'b1, 1'b0);
    step(1'b1, 3000, 16'hFFFF, 1'b0, 1'b0);
    idle(4);

    // Negative floor: -1 then -2.
    step(1'b1, -3, 16'h8000, 1'b1, 1'b0);
    step(1'b1, -4, 16'h8000, 1'b0, 1'b0);
    idle(4);

    // Random samples and gains in PLAY, with gaps.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), longint'(int'($urandom())),
           16'($urandom()), 1'b0, 1'b0);
    idle(4);

    // Release ramp to IDLE, then silence.
    step(1'b1, 65536, 16'hFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 65536, 16'hFFFF, 1'b0, 1'b0);
    step(1'b1, 65536, 16'hFFFF, 1'b0, 1'b1);
    for (int i = 0; i < 1024; i++) step(1'b1, 65536, 16'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 65536, 16'hFFFF, 1'b0, 1'b0);
    chk("rel_idle", longint'(bus.state), 0);
    step(1'b1, 100, 16'hFFFF, 1'b0, 1'b1);
    idle(4);

    // trig beats note_off during RELEASE.
    step(1'b1, 2000, 16'hFFFF, 1'b1, 1'b0);
    step(1'b1, 4000, 16'hFFFF, 1'b0, 1'b0);
    step(1'b1, 4000, 16'hFFFF, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, -7000, 16'hC000, 1'b0, 1'b0);
    step(1'b1, 5000, 16'hFFFF, 1'b1, 1'b1);
    step(1'b1, 5000, 16'hFFFF, 1'b0, 1'b0);
    chk("prio_state", longint'(bus.state), 1);
    idle(4);

    // Reset with three samples in flight: none of them may emerge.
    step(1'b1, 1234, 16'hFFFF, 1'b1, 1'b0);
    step(1'b1, 2345, 16'hFFFF, 1'b0, 1'b0);
    step(1'b1, 3456, 16'hFFFF, 1'b0, 1'b0);
    do_reset(1);
    idle(6);
    chk("post_rst_dfilter", longint'(bus.dfilter), 0);
    chk("post_rst_state", longint'(bus.state), 0);

    chk("sb_drained", longint'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
